// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational 64-bit ALU: accepts an op request, holds the ALU
// inputs for the op's settle time, captures result/flags and returns a response.
module alu_op_sequencer #(
   parameter int WIDTH       = 64,
   parameter int SETTLE_FAST = 1,
   parameter int SETTLE_MUL  = 4,
   parameter int SETTLE_DIV  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_select,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_error,
   output logic             busy
);

   localparam int SETTLE_MD  = (SETTLE_DIV > SETTLE_MUL) ? SETTLE_DIV : SETTLE_MUL;
   localparam int SETTLE_MAX = (SETTLE_MD > SETTLE_FAST) ? SETTLE_MD : SETTLE_FAST;
   localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_select_q, alu_select_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_overflow_q, rsp_overflow_d;
   logic             rsp_error_q, rsp_error_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   function automatic logic [CNT_W-1:0] settle_of(input logic [2:0] op);
      case (op)
         OP_MUL:  return CNT_W'(SETTLE_MUL);
         OP_DIV:  return CNT_W'(SETTLE_DIV);
         default: return CNT_W'(SETTLE_FAST);
      endcase
   endfunction

   always_comb begin
      // NOTE: every _d starts as its _q, so any path that does not assign it holds state and no latch is inferred.
      state_d        = state_q;
      cnt_d          = cnt_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_select_d   = alu_select_q;
      rsp_result_d   = rsp_result_q;
      rsp_zero_d     = rsp_zero_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_error_d    = rsp_error_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_op == 3'd0 || req_op == 3'd7) begin
                  state_d        = RESP;
                  rsp_result_d   = '0;
                  rsp_zero_d     = 1'b0;
                  rsp_overflow_d = 1'b0;
                  rsp_error_d    = 1'b1;
               end else if (req_op == OP_DIV && req_b == '0) begin
                  state_d        = RESP;
                  rsp_result_d   = '1;
                  rsp_zero_d     = 1'b0;
                  rsp_overflow_d = 1'b0;
                  rsp_error_d    = 1'b1;
               end else begin
                  state_d      = ISSUE;
                  alu_a_d      = req_a;
                  alu_b_d      = req_b;
                  alu_select_d = req_op;
                  cnt_d        = settle_of(req_op);
               end
            end
         end
         ISSUE: begin
            if (cnt_q == CNT_W'(1)) begin
               // Zero is derived from the captured value; the ALU's own zero flag is not wired in.
               rsp_result_d   = alu_result;
               rsp_zero_d     = ~|alu_result;
               rsp_overflow_d = (alu_select_q == OP_ADD || alu_select_q == OP_SUB) ? alu_overflow : 1'b0;
               rsp_error_d    = 1'b0;
               alu_select_d   = '0;
               state_d        = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Handshake/status outputs are registered from the next state.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values together.
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_select_q   <= '0;
         rsp_result_q   <= '0;
         rsp_zero_q     <= 1'b0;
         rsp_overflow_q <= 1'b0;
         rsp_error_q    <= 1'b0;
         req_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_select_q   <= alu_select_d;
         rsp_result_q   <= rsp_result_d;
         rsp_zero_q     <= rsp_zero_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_error_q    <= rsp_error_d;
         req_ready_q    <= req_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign busy         = busy_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_select   = alu_select_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_overflow = rsp_overflow_q;
   assign rsp_error    = rsp_error_q;

endmodule
